// File: rtl/mpc_jtag_debug_sysclk_mc_if.sv
// Per-core debug action handshake between the sysclk bridge (master) and the cores (slave).
interface mpc_jtag_debug_sysclk_mc_if #(
  parameter int NUM_CORES = 5,
  parameter int IR_W      = 2
);
  logic [NUM_CORES-1:0] action_valid;
  logic [NUM_CORES-1:0] action_ready;
  logic [IR_W+1:0]      action_code;

  modport master (output action_valid, output action_code, input action_ready);
  modport slave  (input action_valid, input action_code, output action_ready);
endinterface

// File: rtl/mpc_jtag_debug_sysclk_mc.sv
// Sysclk half of the multi-core JTAG debug bridge: synchronises TCK update strobes,
// captures the scan register and hands one action command to one core or all cores.
module mpc_jtag_debug_sysclk_mc #(
  parameter int NUM_CORES   = 5,
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int CSEL_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [SR_W-1:0]   sr,
  input  logic [CSEL_W-1:0] core_sel,
  input  logic              vs_uir,
  input  logic              vs_udr,
  input  logic              status_clr,
  output logic [SR_W-1:0]   jdo,
  output logic              busy,
  output logic              overrun,
  output logic              bad_sel,
  mpc_jtag_debug_sysclk_mc_if.master act
);

  typedef enum logic [1:0] {IDLE, DEC, HOLD} state_t;

  localparam logic [NUM_CORES-1:0] ONE_HOT0 = NUM_CORES'(1);

  state_t               state;
  logic [SYNC_STAGES:0] uir_sync;
  logic [SYNC_STAGES:0] udr_sync;
  logic                 uir_ev;
  logic                 udr_ev;
  logic [IR_W-1:0]      ir_q;
  logic [CSEL_W-1:0]    sel_q;
  logic [NUM_CORES-1:0] pend;
  logic [NUM_CORES-1:0] pend_nxt;
  logic [IR_W+1:0]      code_q;
  logic                 sel_bcast;
  logic                 sel_ok;
  logic                 bad_dec;
  logic                 drop_ev;

  // Synchroniser stages: the top bit is the previous value used for rising-edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync <= '0;
      udr_sync <= '0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-1:0], vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-1:0], vs_udr};
    end
  end

  assign uir_ev    = uir_sync[SYNC_STAGES-1] & ~uir_sync[SYNC_STAGES];
  assign udr_ev    = udr_sync[SYNC_STAGES-1] & ~udr_sync[SYNC_STAGES];
  assign sel_bcast = (sel_q == {CSEL_W{1'b1}});
  assign sel_ok    = (32'(sel_q) < 32'(NUM_CORES));
  assign bad_dec   = (state == DEC) && !sel_bcast && !sel_ok;
  assign drop_ev   = udr_ev && (state != IDLE);
  // A ready on a bit that is not pending has no effect because the bit is already clear
  assign pend_nxt  = pend & ~act.action_ready;

  assign busy             = (state == HOLD);
  assign act.action_valid = pend;
  assign act.action_code  = code_q;

  // Capture / decode / hold control
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ir_q    <= '0;
      sel_q   <= '0;
      jdo     <= '0;
      pend    <= '0;
      code_q  <= '0;
      overrun <= 1'b0;
      bad_sel <= 1'b0;
    end else begin
      if (uir_ev) ir_q <= ir_in;

      if (status_clr)   overrun <= 1'b0;
      else if (drop_ev) overrun <= 1'b1;

      if (status_clr)   bad_sel <= 1'b0;
      else if (bad_dec) bad_sel <= 1'b1;

      case (state)
        IDLE: begin
          if (udr_ev) begin
            jdo   <= sr;
            sel_q <= core_sel;
            state <= DEC;
          end
        end
        DEC: begin
          if (sel_bcast || sel_ok) begin
            pend   <= sel_bcast ? {NUM_CORES{1'b1}} : (ONE_HOT0 << sel_q);
            code_q <= {ir_q, jdo[35], jdo[34]};
            state  <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          pend <= pend_nxt;
          if (pend_nxt == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
